// File: rtl/alu_unit.sv
// Registered integer ALU: arithmetic and logical command sets with one-cycle latency.
// Error and status flags are recomputed on every issued operation, never held.
module alu_unit #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic [1:0]      INP_VALID,
    input  logic            MODE,
    input  logic [CW-1:0]   CMD,
    input  logic [N-1:0]    OPA,
    input  logic [N-1:0]    OPB,
    input  logic            CIN,
    output logic [2*N-1:0]  RES,
    output logic            COUT,
    output logic            OFLOW,
    output logic            G,
    output logic            L,
    output logic            E,
    output logic            ERR
);

    localparam int unsigned LW = $clog2(N);

    // Arithmetic commands
    localparam logic [CW-1:0] ArAdd    = CW'(0);
    localparam logic [CW-1:0] ArSub    = CW'(1);
    localparam logic [CW-1:0] ArAddCin = CW'(2);
    localparam logic [CW-1:0] ArSubCin = CW'(3);
    localparam logic [CW-1:0] ArIncA   = CW'(4);
    localparam logic [CW-1:0] ArDecA   = CW'(5);
    localparam logic [CW-1:0] ArIncB   = CW'(6);
    localparam logic [CW-1:0] ArDecB   = CW'(7);
    localparam logic [CW-1:0] ArCmp    = CW'(8);
    localparam logic [CW-1:0] ArMulInc = CW'(9);
    localparam logic [CW-1:0] ArMulShl = CW'(10);

    // Logical commands
    localparam logic [CW-1:0] LgAnd  = CW'(0);
    localparam logic [CW-1:0] LgNand = CW'(1);
    localparam logic [CW-1:0] LgOr   = CW'(2);
    localparam logic [CW-1:0] LgNor  = CW'(3);
    localparam logic [CW-1:0] LgXor  = CW'(4);
    localparam logic [CW-1:0] LgXnor = CW'(5);
    localparam logic [CW-1:0] LgNotA = CW'(6);
    localparam logic [CW-1:0] LgNotB = CW'(7);
    localparam logic [CW-1:0] LgShrA = CW'(8);
    localparam logic [CW-1:0] LgShlA = CW'(9);
    localparam logic [CW-1:0] LgShrB = CW'(10);
    localparam logic [CW-1:0] LgShlB = CW'(11);
    localparam logic [CW-1:0] LgRolA = CW'(12);
    localparam logic [CW-1:0] LgRorA = CW'(13);

    localparam logic [1:0] NeedA    = 2'b01;
    localparam logic [1:0] NeedB    = 2'b10;
    localparam logic [1:0] NeedBoth = 2'b11;

    logic [2*N-1:0] res_d, res_q;
    logic           cout_d, cout_q, oflow_d, oflow_q;
    logic           g_d, g_q, l_d, l_q, e_d, e_q, err_d, err_q;

    logic [N:0]     sum_ab, sum_abc, inc_a, inc_b, b_plus_cin;
    logic [N-1:0]   diff, diff_cin, dec_a, dec_b, a_shl, lo;
    logic [2*N-1:0] mul_inc, mul_shl;
    logic [LW-1:0]  amt;
    logic [N-1:0]   rol, ror;
    logic           rot_bad, illegal;
    logic [1:0]     need;

    always_comb begin
        sum_ab     = {1'b0, OPA} + {1'b0, OPB};
        sum_abc    = sum_ab + {{N{1'b0}}, CIN};
        b_plus_cin = {1'b0, OPB} + {{N{1'b0}}, CIN};
        inc_a      = {1'b0, OPA} + {{N{1'b0}}, 1'b1};
        inc_b      = {1'b0, OPB} + {{N{1'b0}}, 1'b1};
        diff       = OPA - OPB;
        diff_cin   = OPA - OPB - {{(N-1){1'b0}}, CIN};
        dec_a      = OPA - {{(N-1){1'b0}}, 1'b1};
        dec_b      = OPB - {{(N-1){1'b0}}, 1'b1};
        a_shl      = OPA << 1;
        mul_inc    = {{(N-1){1'b0}}, inc_a} * {{(N-1){1'b0}}, inc_b};
        mul_shl    = {{N{1'b0}}, a_shl} * {{N{1'b0}}, OPB};
        amt        = OPB[LW-1:0];
        rot_bad    = |(OPB >> LW);
        // A shift by N yields zero, which covers the amt == 0 case.
        rol        = (OPA << amt) | (OPA >> (N - amt));
        ror        = (OPA >> amt) | (OPA << (N - amt));
    end

    always_comb begin
        res_d   = '0;
        cout_d  = 1'b0;
        oflow_d = 1'b0;
        g_d     = 1'b0;
        l_d     = 1'b0;
        e_d     = 1'b0;
        err_d   = 1'b0;
        lo      = '0;
        need    = NeedBoth;
        illegal = 1'b0;

        if (MODE) begin
            case (CMD)
                ArAdd:    begin res_d = {{(N-1){1'b0}}, sum_ab};  cout_d = sum_ab[N];  end
                ArSub:    begin res_d = {{N{1'b0}}, diff};        oflow_d = OPA < OPB; end
                ArAddCin: begin res_d = {{(N-1){1'b0}}, sum_abc}; cout_d = sum_abc[N]; end
                ArSubCin: begin
                    res_d   = {{N{1'b0}}, diff_cin};
                    oflow_d = {1'b0, OPA} < b_plus_cin;
                end
                ArIncA: begin
                    need = NeedA; res_d = {{(N-1){1'b0}}, inc_a}; cout_d = inc_a[N];
                end
                ArDecA: begin
                    need = NeedA; res_d = {{N{1'b0}}, dec_a}; oflow_d = OPA == '0;
                end
                ArIncB: begin
                    need = NeedB; res_d = {{(N-1){1'b0}}, inc_b}; cout_d = inc_b[N];
                end
                ArDecB: begin
                    need = NeedB; res_d = {{N{1'b0}}, dec_b}; oflow_d = OPB == '0;
                end
                ArCmp: begin
                    g_d = OPA > OPB;
                    l_d = OPA < OPB;
                    e_d = OPA == OPB;
                end
                ArMulInc: res_d = mul_inc;
                ArMulShl: res_d = mul_shl;
                default:  illegal = 1'b1;
            endcase
        end else begin
            case (CMD)
                LgAnd:  lo = OPA & OPB;
                LgNand: lo = ~(OPA & OPB);
                LgOr:   lo = OPA | OPB;
                LgNor:  lo = ~(OPA | OPB);
                LgXor:  lo = OPA ^ OPB;
                LgXnor: lo = ~(OPA ^ OPB);
                LgNotA: begin need = NeedA; lo = ~OPA;      end
                LgNotB: begin need = NeedB; lo = ~OPB;      end
                LgShrA: begin need = NeedA; lo = OPA >> 1;  end
                LgShlA: begin need = NeedA; lo = OPA << 1;  end
                LgShrB: begin need = NeedB; lo = OPB >> 1;  end
                LgShlB: begin need = NeedB; lo = OPB << 1;  end
                LgRolA: begin lo = rol; illegal = rot_bad;  end
                LgRorA: begin lo = ror; illegal = rot_bad;  end
                default: illegal = 1'b1;
            endcase
            res_d = {{N{1'b0}}, lo};
        end

        // Idle beats report nothing; errors suppress every other output.
        if (INP_VALID == 2'b00 || illegal || (need & ~INP_VALID) != 2'b00) begin
            res_d   = '0;
            cout_d  = 1'b0;
            oflow_d = 1'b0;
            g_d     = 1'b0;
            l_d     = 1'b0;
            e_d     = 1'b0;
            err_d   = INP_VALID != 2'b00;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            err_q   <= 1'b0;
        end else if (CE) begin
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
            err_q   <= err_d;
        end
    end

    assign RES   = res_q;
    assign COUT  = cout_q;
    assign OFLOW = oflow_q;
    assign G     = g_q;
    assign L     = l_q;
    assign E     = e_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: the driver queues hand-computed results, a monitor
// compares each registered output one edge later.
module tb_alu_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CE = 1'b0;
    logic [1:0]  INP_VALID = '0;
    logic        MODE = 1'b0;
    logic [3:0]  CMD = '0;
    logic [7:0]  OPA = '0;
    logic [7:0]  OPB = '0;
    logic        CIN = 1'b0;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, L, E, ERR;

    alu_unit #(.N(8), .CW(4)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE), .CMD(CMD),
        .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
        .G(G), .L(L), .E(E), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [5:0]  fl;   // {cout, oflow, g, l, e, err}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic arm = 1'b0;

    // Monitor: outputs launched at this edge are compared 1 time unit later.
    always @(posedge CLK) begin
        if (arm) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow: output present with no expected entry");
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (RES !== x.res || {COUT, OFLOW, G, L, E, ERR} !== x.fl) begin
                    errors++;
                    $display("FAIL %s: got res=%h flags(c,o,g,l,e,err)=%b, exp res=%h flags=%b",
                             x.name, RES, {COUT, OFLOW, G, L, E, ERR}, x.res, x.fl);
                end
            end
        end
    end

    task automatic drive(input string nm, input logic rst, input logic ce,
                         input logic [1:0] iv, input logic mode, input logic [3:0] cmd,
                         input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [15:0] res, input logic [5:0] fl);
        exp_t x;
        @(negedge CLK);
        RST = rst; CE = ce; INP_VALID = iv; MODE = mode; CMD = cmd;
        OPA = a; OPB = b; CIN = cin;
        x.name = nm; x.res = res; x.fl = fl;
        exp_q.push_back(x);
        arm = 1'b1;
    endtask

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            drive("reset", 1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 4'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom), 16'h0000, 6'b000000);

        // Arithmetic
        drive("add_ff_01",   0, 1, 2'b11, 1, 4'd0, 8'hFF, 8'h01, 0, 16'h0100, 6'b100000);
        drive("subc_borrow", 0, 1, 2'b11, 1, 4'd3, 8'd5, 8'd5, 1, 16'h00FF, 6'b010000);
        drive("subc_zero",   0, 1, 2'b11, 1, 4'd3, 8'd5, 8'd5, 0, 16'h0000, 6'b000000);
        drive("addc_carry",  0, 1, 2'b11, 1, 4'd2, 8'h80, 8'h7F, 1, 16'h0100, 6'b100000);
        drive("cmp_lt",      0, 1, 2'b11, 1, 4'd8, 8'd3, 8'd7, 0, 16'h0000, 6'b000100);
        drive("mul_inc_max", 0, 1, 2'b11, 1, 4'd9, 8'd255, 8'd255, 0, 16'h0000, 6'b000000);
        drive("cmp_eq",      0, 1, 2'b11, 1, 4'd8, 8'd9, 8'd9, 0, 16'h0000, 6'b000010);
        drive("cmp_gt",      0, 1, 2'b11, 1, 4'd8, 8'd9, 8'd2, 0, 16'h0000, 6'b001000);
        drive("mul_inc_2_3", 0, 1, 2'b11, 1, 4'd9, 8'd2, 8'd3, 0, 16'h000C, 6'b000000);
        drive("mul_shl_3_4", 0, 1, 2'b11, 1, 4'd10, 8'd3, 8'd4, 0, 16'h0018, 6'b000000);
        drive("mul_shl_wrap", 0, 1, 2'b11, 1, 4'd10, 8'h80, 8'd5, 0, 16'h0000, 6'b000000);
        drive("dec_a_zero",  0, 1, 2'b01, 1, 4'd5, 8'h00, 8'h00, 0, 16'h00FF, 6'b010000);
        drive("inc_b",       0, 1, 2'b10, 1, 4'd6, 8'h00, 8'd7, 0, 16'h0008, 6'b000000);
        drive("dec_b_zero",  0, 1, 2'b10, 1, 4'd7, 8'h00, 8'h00, 0, 16'h00FF, 6'b010000);

        // Logical
        drive("rol_81_1",    0, 1, 2'b11, 0, 4'd12, 8'h81, 8'h01, 0, 16'h0003, 6'b000000);
        drive("ror_bad_amt", 0, 1, 2'b11, 0, 4'd13, 8'h81, 8'h10, 0, 16'h0000, 6'b000001);
        drive("ror_81_1",    0, 1, 2'b11, 0, 4'd13, 8'h81, 8'h01, 0, 16'h00C0, 6'b000000);
        drive("rol_81_0",    0, 1, 2'b11, 0, 4'd12, 8'h81, 8'h00, 0, 16'h0081, 6'b000000);
        drive("nand",        0, 1, 2'b11, 0, 4'd1, 8'hF0, 8'h3C, 1, 16'h00CF, 6'b000000);
        drive("xor",         0, 1, 2'b11, 0, 4'd4, 8'hF0, 8'h3C, 0, 16'h00CC, 6'b000000);
        drive("nor",         0, 1, 2'b11, 0, 4'd3, 8'hF0, 8'h3C, 0, 16'h0003, 6'b000000);
        drive("not_b",       0, 1, 2'b10, 0, 4'd7, 8'h00, 8'h0F, 0, 16'h00F0, 6'b000000);
        drive("shl1_b",      0, 1, 2'b10, 0, 4'd11, 8'h00, 8'h81, 0, 16'h0002, 6'b000000);
        drive("shr1_a",      0, 1, 2'b01, 0, 4'd8, 8'h81, 8'h00, 0, 16'h0040, 6'b000000);
        drive("log_illegal", 0, 1, 2'b11, 0, 4'd14, 8'h12, 8'h34, 0, 16'h0000, 6'b000001);
        drive("not_a_no_a",  0, 1, 2'b10, 0, 4'd6, 8'h12, 8'h34, 0, 16'h0000, 6'b000001);

        // Validity / illegal
        drive("add_only_a",  0, 1, 2'b01, 1, 4'd0, 8'h01, 8'h01, 0, 16'h0000, 6'b000001);
        drive("inc_a_ff",    0, 1, 2'b01, 1, 4'd4, 8'hFF, 8'h00, 0, 16'h0100, 6'b100000);
        drive("ar_illegal",  0, 1, 2'b11, 1, 4'd12, 8'h01, 8'h01, 0, 16'h0000, 6'b000001);
        drive("idle",        0, 1, 2'b00, 1, 4'd15, 8'hAA, 8'h55, 1, 16'h0000, 6'b000000);

        // CE hold, then reset while CE is low
        drive("hold_src",    0, 1, 2'b11, 1, 4'd1, 8'd3, 8'd5, 0, 16'h00FE, 6'b010000);
        drive("hold_1",      0, 0, 2'b11, 1, 4'd0, 8'hFF, 8'hFF, 1, 16'h00FE, 6'b010000);
        drive("hold_2",      0, 0, 2'b01, 0, 4'd14, 8'h12, 8'h00, 0, 16'h00FE, 6'b010000);
        drive("hold_3",      0, 0, 2'b11, 1, 4'd8, 8'd1, 8'd9, 0, 16'h00FE, 6'b010000);
        drive("rst_ce_low",  1, 0, 2'b11, 1, 4'd0, 8'hFF, 8'h01, 0, 16'h0000, 6'b000000);

        @(negedge CLK);
        arm = 1'b0;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
